// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit: default widths and arbitration states.
package wb_pkg;

  localparam int DEFAULT_XLEN         = 32;
  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int NUM_REGS             = 32;

  // Which source wins when both offer a result in the same cycle.
  typedef enum logic {
    PRIO_MEM = 1'b0,
    PRIO_ALU = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard: tracks registers awaiting a long-latency result.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_valid,
  input  logic [4:0] set_rd,
  input  logic       clr_valid,
  input  logic [4:0] clr_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // Per-register update; x0 is hardwired idle, and a set beats a same-cycle clear.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_bit
      assign busy_next[gi] = (set_valid && (set_rd == 5'(gi))) ? 1'b1 :
                             (clr_valid && (clr_rd == 5'(gi))) ? 1'b0 :
                             busy_reg[gi];
    end
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign hazard = busy_reg[rs1] | busy_reg[rs2];

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: merges ALU and memory results into one register-file write
// port, with starvation protection for the ALU and a pending-load scoreboard.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard,
  output logic            RegWrite,
  output logic [4:0]      WriteReg,
  output logic [XLEN-1:0] WriteData,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t      state_reg, state_next;
  logic [CW-1:0]   starve_cnt_reg, starve_cnt_next;
  logic            wr_en_reg;
  logic [4:0]      wr_rd_reg;
  logic [XLEN-1:0] wr_data_reg;
  logic            alu_acc, mem_acc, alu_denied;

  assign alu_acc    = alu_valid && alu_ready;
  assign mem_acc    = mem_valid && mem_ready;
  assign alu_denied = alu_valid && !alu_ready;

  // Grant logic: the priority source is always ready, the other only when the
  // priority source is idle. Nothing is granted while reset is held.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (rst) begin
      case (state_reg)
        PRIO_MEM: begin
          mem_ready = 1'b1;
          alu_ready = !mem_valid;
        end
        PRIO_ALU: begin
          alu_ready = 1'b1;
          mem_ready = !alu_valid;
        end
        default: begin
          mem_ready = 1'b1;
          alu_ready = !mem_valid;
        end
      endcase
    end
  end

  // Next-state and starvation counter: hand priority to the ALU on the denial
  // that brings the count to the limit, so the ALU wins the very next cycle.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    if (alu_acc) begin
      starve_cnt_next = '0;
    end else if (alu_denied) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
    case (state_reg)
      PRIO_MEM: begin
        if (alu_denied && (starve_cnt_reg + 1'b1 == CW'(STARVE_LIMIT))) begin
          state_next      = PRIO_ALU;
          starve_cnt_next = '0;
        end
      end
      PRIO_ALU: begin
        if (alu_acc) begin
          state_next = PRIO_MEM;
        end
      end
      default: state_next = PRIO_MEM;
    endcase
  end

  // State, counter and registered write port; x0 results are consumed silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= PRIO_MEM;
      starve_cnt_reg <= '0;
      wr_en_reg      <= 1'b0;
      wr_rd_reg      <= '0;
      wr_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      wr_en_reg      <= (alu_acc && (alu_rd != 5'd0)) || (mem_acc && (mem_rd != 5'd0));
      if (alu_acc) begin
        wr_rd_reg   <= alu_rd;
        wr_data_reg <= alu_data;
      end else if (mem_acc) begin
        wr_rd_reg   <= mem_rd;
        wr_data_reg <= mem_data;
      end
    end
  end

  assign RegWrite  = wr_en_reg;
  assign WriteReg  = wr_rd_reg;
  assign WriteData = wr_data_reg;
  assign fwd_valid = wr_en_reg;
  assign fwd_rd    = wr_rd_reg;
  assign fwd_data  = wr_data_reg;

  // Only accepted memory results retire pending destinations.
  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (issue_valid),
    .set_rd    (issue_rd),
    .clr_valid (mem_acc),
    .clr_rd    (mem_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .hazard    (hazard)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, mem_valid, issue_valid;
  logic [4:0]      alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready, hazard;
  logic            RegWrite, fwd_valid;
  logic [4:0]      WriteReg, fwd_rd;
  logic [XLEN-1:0] WriteData, fwd_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic test_reset();
    rst = 0; idle(); rs1 = 0; rs2 = 0;
    tick(); tick();
    alu_valid = 1; alu_rd = 3; alu_data = 9; mem_valid = 1; mem_rd = 4; mem_data = 8;
    #1;
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL reset_alu_ready got=%0b exp=0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_ready got=%0b exp=0", mem_ready); end
    tick();
    checks++; if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== 32'd0)
      begin failures++; $display("FAIL reset_wport got=%0b/%0d/%0d exp=0/0/0", RegWrite, WriteReg, WriteData); end
    checks++; if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0)
      begin failures++; $display("FAIL reset_fwd got=%0b/%0d/%0d exp=0/0/0", fwd_valid, fwd_rd, fwd_data); end
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%0b exp=0", hazard); end
    idle(); rst = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_alu_alone();
    alu_valid = 1; alu_rd = 1; alu_data = 32;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%0b exp=1", alu_ready); end
    tick(); idle();
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd1 || WriteData !== 32'd32)
      begin failures++; $display("FAIL alu_write got=%0b/%0d/%0d exp=1/1/32", RegWrite, WriteReg, WriteData); end
    checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd1 || fwd_data !== 32'd32)
      begin failures++; $display("FAIL alu_fwd got=%0b/%0d/%0d exp=1/1/32", fwd_valid, fwd_rd, fwd_data); end
    tick();
    checks++; if (RegWrite !== 1'b0 || WriteReg !== 5'd1 || WriteData !== 32'd32)
      begin failures++; $display("FAIL idle_hold got=%0b/%0d/%0d exp=0/1/32", RegWrite, WriteReg, WriteData); end
    $display("test_alu_alone done");
  endtask

  task automatic test_conflict();
    alu_valid = 1; alu_rd = 31; alu_data = 21;
    mem_valid = 1; mem_rd = 5;  mem_data = 200;
    #1;
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0)
      begin failures++; $display("FAIL conflict_grant got=mem%0b/alu%0b exp=mem1/alu0", mem_ready, alu_ready); end
    tick();
    mem_valid = 0;
    #1;
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'd200)
      begin failures++; $display("FAIL conflict_mem_write got=%0b/%0d/%0d exp=1/5/200", RegWrite, WriteReg, WriteData); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL conflict_alu_ready got=%0b exp=1", alu_ready); end
    tick(); idle();
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd31 || WriteData !== 32'd21)
      begin failures++; $display("FAIL conflict_alu_write got=%0b/%0d/%0d exp=1/31/21", RegWrite, WriteReg, WriteData); end
    tick();
    $display("test_conflict done");
  endtask

  task automatic test_starvation();
    logic exp_alu_rdy;
    logic [4:0] exp_rd;
    logic [31:0] exp_data;
    alu_valid = 1; alu_rd = 9; alu_data = 99;
    mem_valid = 1; mem_rd = 3;
    for (int i = 0; i < 6; i++) begin
      mem_data = 32'(100 + i);
      if (i == 5) begin alu_rd = 10; alu_data = 77; end
      exp_alu_rdy = (i == 4);
      #1;
      checks++; if (alu_ready !== exp_alu_rdy || mem_ready !== !exp_alu_rdy)
        begin failures++; $display("FAIL starve_grant cyc=%0d got=alu%0b/mem%0b exp=alu%0b/mem%0b", i, alu_ready, mem_ready, exp_alu_rdy, !exp_alu_rdy); end
      tick();
      exp_rd   = (i == 4) ? 5'd9 : 5'd3;
      exp_data = (i == 4) ? 32'd99 : 32'(100 + i);
      checks++; if (RegWrite !== 1'b1 || WriteReg !== exp_rd || WriteData !== exp_data)
        begin failures++; $display("FAIL starve_write cyc=%0d got=%0b/%0d/%0d exp=1/%0d/%0d", i, RegWrite, WriteReg, WriteData, exp_rd, exp_data); end
      $display("starve cycle %0d wrote rd=%0d data=%0d", i, WriteReg, WriteData);
    end
    mem_valid = 0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL starve_drain_ready got=%0b exp=1", alu_ready); end
    tick(); idle();
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd10 || WriteData !== 32'd77)
      begin failures++; $display("FAIL starve_drain_write got=%0b/%0d/%0d exp=1/10/77", RegWrite, WriteReg, WriteData); end
    tick();
    $display("test_starvation done");
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 0; alu_data = 128;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%0b exp=1", alu_ready); end
    tick(); idle();
    checks++; if (RegWrite !== 1'b0 || fwd_valid !== 1'b0)
      begin failures++; $display("FAIL x0_write got=%0b/%0b exp=0/0", RegWrite, fwd_valid); end
    issue_valid = 1; issue_rd = 0; rs1 = 0; rs2 = 0;
    tick(); idle();
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL x0_busy got=%0b exp=0", hazard); end
    $display("test_x0 done");
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 7; rs1 = 7; rs2 = 0;
    #1;
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL sb_pre_set got=%0b exp=0", hazard); end
    tick(); idle();
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL sb_rs1_hazard got=%0b exp=1", hazard); end
    rs1 = 0; rs2 = 7;
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL sb_rs2_hazard got=%0b exp=1", hazard); end
    mem_valid = 1; mem_rd = 7; mem_data = 55;
    tick(); idle();
    checks++; if (hazard !== 1'b0 || RegWrite !== 1'b1 || WriteReg !== 5'd7)
      begin failures++; $display("FAIL sb_clear got=hz%0b/%0b/%0d exp=hz0/1/7", hazard, RegWrite, WriteReg); end
    // set and clear of the same register in one cycle
    issue_valid = 1; issue_rd = 7;
    tick();
    mem_valid = 1; mem_rd = 7; mem_data = 56;
    tick(); idle();
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL sb_set_wins got=%0b exp=1", hazard); end
    mem_valid = 1; mem_rd = 7; mem_data = 57;
    tick(); idle();
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL sb_cleanup got=%0b exp=0", hazard); end
    // ALU results never retire a pending destination
    issue_valid = 1; issue_rd = 12; rs1 = 12; rs2 = 0;
    tick(); idle();
    alu_valid = 1; alu_rd = 12; alu_data = 3;
    tick(); idle();
    checks++; if (hazard !== 1'b1 || WriteReg !== 5'd12)
      begin failures++; $display("FAIL sb_alu_no_clear got=hz%0b/%0d exp=hz1/12", hazard, WriteReg); end
    mem_valid = 1; mem_rd = 12; mem_data = 4;
    tick(); idle(); rs1 = 0;
    $display("test_scoreboard done");
  endtask

  task automatic test_reset_midflight();
    issue_valid = 1; issue_rd = 9;
    tick(); idle();
    // three ALU denials leave the starvation counter one short of the limit
    alu_valid = 1; alu_rd = 2; alu_data = 5; mem_valid = 1; mem_rd = 6; mem_data = 1;
    tick(); tick(); tick();
    mem_data = 66; rst = 0;
    #1;
    checks++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0)
      begin failures++; $display("FAIL mid_rst_grant got=mem%0b/alu%0b exp=0/0", mem_ready, alu_ready); end
    tick(); rst = 1; rs1 = 9;
    mem_data = 8;
    #1;
    checks++; if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== 32'd0)
      begin failures++; $display("FAIL mid_rst_no_write got=%0b/%0d/%0d exp=0/0/0", RegWrite, WriteReg, WriteData); end
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b exp=0", hazard); end
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0)
      begin failures++; $display("FAIL mid_rst_fsm got=mem%0b/alu%0b exp=1/0", mem_ready, alu_ready); end
    tick();
    mem_data = 9;
    #1;
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd6 || WriteData !== 32'd8)
      begin failures++; $display("FAIL mid_rst_first got=%0b/%0d/%0d exp=1/6/8", RegWrite, WriteReg, WriteData); end
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_counter got=%0b exp=0", alu_ready); end
    tick();
    mem_valid = 0;
    #1;
    checks++; if (alu_ready !== 1'b1 || WriteData !== 32'd9)
      begin failures++; $display("FAIL mid_rst_second got=%0b/%0d exp=1/9", alu_ready, WriteData); end
    tick(); idle(); rs1 = 0;
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd2 || WriteData !== 32'd5)
      begin failures++; $display("FAIL mid_rst_alu got=%0b/%0d/%0d exp=1/2/5", RegWrite, WriteReg, WriteData); end
    $display("test_reset_midflight done");
  endtask

  initial begin
    test_reset();
    test_alu_alone();
    test_conflict();
    test_starvation();
    test_x0();
    test_scoreboard();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32: data width of results and register-file write data.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive ALU denials before ALU gets priority.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 alu_valid / alu_rd / alu_data  input  1 / 5 / XLEN  single-cycle ALU result offer.
REQ-006 alu_ready  output  1  ALU result accepted this cycle (alu_valid && alu_ready).
REQ-007 mem_valid / mem_rd / mem_data  input  1 / 5 / XLEN  load/long-latency result offer.
REQ-008 mem_ready  output  1  memory result accepted this cycle.
REQ-009 issue_valid / issue_rd  input  1 / 5  long-latency op issued; its rd becomes pending.
REQ-010 rs1 / rs2  input  5 / 5  decode-stage source registers for hazard lookup.
REQ-011 hazard  output  1  rs1 or rs2 pending in scoreboard.
REQ-012 RegWrite / WriteReg / WriteData  output  1 / 5 / XLEN  register-file write port.
REQ-013 fwd_valid / fwd_rd / fwd_data  output  1 / 5 / XLEN  bypass of the write in flight, equal to RegWrite/WriteReg/WriteData.

Function
REQ-014 Write-port outputs SHALL be registered: an accepted result appears on RegWrite/WriteReg/WriteData exactly 1 cycle after acceptance, for 1 cycle.
REQ-015 At most one result SHALL be accepted per cycle; a source not accepted holds its offer (valid/rd/data stable) until accepted.
REQ-016 Arbitration FSM states: PRIO_MEM (reset state), PRIO_ALU.
REQ-017 In PRIO_MEM: mem_ready = 1; alu_ready = !mem_valid.
REQ-018 In PRIO_ALU: alu_ready = 1; mem_ready = !alu_valid.
REQ-019 Starvation counter (width ceil(log2(STARVE_LIMIT+1))) SHALL increment on each cycle alu_valid && !alu_ready and clear on any ALU acceptance.
REQ-020 PRIO_MEM -> PRIO_ALU when counter reaches STARVE_LIMIT; PRIO_ALU -> PRIO_MEM on the cycle after ALU acceptance; counter clears on entry to PRIO_ALU.
REQ-021 Accepted result with rd = 0 SHALL be consumed with RegWrite = 0 next cycle (x0 never written); fwd_valid likewise 0.
REQ-022 Scoreboard: 32-bit busy vector; issue_valid sets busy[issue_rd] at next edge; accepted mem result clears busy[mem_rd] at next edge.
REQ-023 Simultaneous set and clear of the same register: set wins.
REQ-024 busy[0] SHALL always read 0; issue_rd = 0 is ignored.
REQ-025 hazard = busy[rs1] | busy[rs2], combinational, from current busy vector.
REQ-026 ALU results SHALL NOT clear busy bits.
REQ-027 No valid offered: RegWrite = 0 next cycle; outputs WriteReg/WriteData hold last value.

Reset
REQ-028 When rst = 0 at a rising edge: RegWrite = 0, WriteReg = 0, WriteData = 0, fwd_* = 0, busy = 0, counter = 0, FSM = PRIO_MEM.
REQ-029 Reset mid-operation SHALL discard any accepted-but-unwritten result; no write is emitted on the first cycle after reset release.
REQ-030 During reset alu_ready and mem_ready SHALL be 0.

Structure
REQ-031 Shared package wb_pkg SHALL hold XLEN, STARVE_LIMIT default, and the arbitration state enum (PRIO_MEM, PRIO_ALU).
REQ-032 Scoreboard SHALL be a sub-module wb_scoreboard (busy vector, set/clear, hazard lookup); arbiter, counter and output registers stay in writeback_unit.
REQ-033 Target size 120-400 lines RTL total.

Verification
REQ-034 ALU alone: alu rd=1 data=32 -> next cycle RegWrite=1, WriteReg=1, WriteData=32; fwd_* identical.
REQ-035 Conflict: alu (rd=31, 21) and mem (rd=5, 200) same cycle, PRIO_MEM -> mem written first, ALU written one cycle later, ALU data held stable throughout.
REQ-036 Starvation: mem_valid held high 6 cycles, alu_valid high -> ALU denied 4 cycles, accepted on 5th, mem_ready low that cycle, FSM back to PRIO_MEM after.
REQ-037 x0: alu rd=0 data=128 -> alu_ready=1, next cycle RegWrite=0; issue_rd=0 -> busy[0] stays 0.
REQ-038 Scoreboard: issue rd=7; rs1=7 -> hazard=1; mem rd=7 accepted -> hazard=0 the cycle RegWrite=1 WriteReg=7; issue rd=7 and mem clear rd=7 same cycle -> busy[7] stays 1.
REQ-039 Reset mid-flight: assert rst=0 the cycle a mem result is accepted -> no write emitted, busy=0, FSM=PRIO_MEM after release.
